// File: rtl/instr_readout_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_readout_seq
// Purpose  : Sweeps read_pointer over an address range of the instruction
//            register and streams each captured entry on a valid/ready port.
//            Optional result re-check enabled by INSTR_READOUT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_readout_seq #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] read_pointer,
  input  logic [3:0]        iw_opc,
  input  logic [31:0]       iw_op_a,
  input  logic [31:0]       iw_op_b,
  input  logic [63:0]       iw_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [3:0]        out_opc,
  output logic [31:0]       out_op_a,
  output logic [31:0]       out_op_b,
  output logic [63:0]       out_result,
  output logic              out_mismatch,
  output logic [ADDR_W:0]   mismatch_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_fetch = 2'd1;
  localparam logic [1:0] c_st_hold  = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [ADDR_W:0]   c_one      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_last_adr = ADDR_W'(DEPTH-1);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [ADDR_W:0] r_remaining;
  logic            w_handshake;

  assign w_handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_st_idle;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (start) w_next_state = (count != '0) ? c_st_fetch : c_st_done;
      c_st_fetch: w_next_state = c_st_hold;
      c_st_hold:  if (w_handshake) w_next_state = (r_remaining == c_one) ? c_st_done : c_st_fetch;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state != c_st_idle);
    done = (r_state == c_st_done);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer <= '0;
      r_remaining  <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_opc      <= '0;
      out_op_a     <= '0;
      out_op_b     <= '0;
      out_result   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start && (count != '0)) begin
            read_pointer <= start_addr;
            r_remaining  <= count;
          end
        end
        c_st_fetch: begin
          out_addr   <= read_pointer;
          out_opc    <= iw_opc;
          out_op_a   <= iw_op_a;
          out_op_b   <= iw_op_b;
          out_result <= iw_result;
          out_valid  <= 1'b1;
        end
        c_st_hold: begin
          if (w_handshake) begin
            out_valid <= 1'b0;
            if (r_remaining != c_one) begin
              read_pointer <= (read_pointer == c_last_adr) ? '0 : read_pointer + 1'b1;
              r_remaining  <= r_remaining - c_one;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef INSTR_READOUT_CHECK_EN
  logic signed [63:0] w_a;
  logic signed [63:0] w_b;
  logic signed [63:0] w_expected;
  logic               w_checked;
  logic               w_bad;
  logic               r_mismatch;
  logic [ADDR_W:0]    r_mismatch_cnt;

  // Operands are sign-extended so products and quotients are exact in 64 bits.
  always_comb begin
    w_a        = {{32{iw_op_a[31]}}, iw_op_a};
    w_b        = {{32{iw_op_b[31]}}, iw_op_b};
    w_expected = '0;
    w_checked  = 1'b1;
    case (iw_opc)
      4'd0:    w_expected = '0;
      4'd1:    w_expected = w_a;
      4'd2:    w_expected = w_b;
      4'd3:    w_expected = w_a + w_b;
      4'd4:    w_expected = w_a - w_b;
      4'd5:    w_expected = w_a * w_b;
      4'd6:    w_expected = (w_b == '0) ? '0 : w_a / w_b;
      4'd7:    w_expected = (w_b == '0) ? '0 : w_a % w_b;
      default: w_checked  = 1'b0;
    endcase
    w_bad = w_checked && (w_expected != $signed(iw_result));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mismatch     <= 1'b0;
      r_mismatch_cnt <= '0;
    end else if ((r_state == c_st_idle) && start) begin
      r_mismatch_cnt <= '0;
    end else if (r_state == c_st_fetch) begin
      r_mismatch <= w_bad;
      if (w_bad && (r_mismatch_cnt != '1)) r_mismatch_cnt <= r_mismatch_cnt + c_one;
    end
  end

  assign out_mismatch = r_mismatch;
  assign mismatch_cnt = r_mismatch_cnt;
`else
  assign out_mismatch = 1'b0;
  assign mismatch_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_readout_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_readout_seq
// Purpose  : Scoreboard bench for instr_readout_seq with a behavioural
//            instruction-register model and randomized sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_readout_seq;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic [ADDR_W-1:0] read_pointer;
  logic [3:0]        iw_opc;
  logic [31:0]       iw_op_a, iw_op_b;
  logic [63:0]       iw_result;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_addr;
  logic [3:0]        out_opc;
  logic [31:0]       out_op_a, out_op_b;
  logic [63:0]       out_result;
  logic              out_mismatch;
  logic [ADDR_W:0]   mismatch_cnt;
  logic              busy, done;

  instr_readout_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .count(count), .read_pointer(read_pointer), .iw_opc(iw_opc),
    .iw_op_a(iw_op_a), .iw_op_b(iw_op_b), .iw_result(iw_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_opc(out_opc), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_result(out_result), .out_mismatch(out_mismatch),
    .mismatch_cnt(mismatch_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Instruction register model: combinational read from read_pointer.
  logic [3:0]  m_opc [DEPTH];
  logic [31:0] m_a   [DEPTH];
  logic [31:0] m_b   [DEPTH];
  logic [63:0] m_res [DEPTH];
  assign iw_opc    = m_opc[read_pointer];
  assign iw_op_a   = m_a[read_pointer];
  assign iw_op_b   = m_b[read_pointer];
  assign iw_result = m_res[read_pointer];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        opc;
    logic [31:0]       a, b;
    logic [63:0]       res;
    logic              bad;
    logic [ADDR_W:0]   cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int done_seen = 0, done_exp = 0, hs_count = 0, valid_seen = 0;
  int rmode = 0, lowcnt = 0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint model_expected(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    longint la, lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (opc)
      4'd1:    return la;
      4'd2:    return lb;
      4'd3:    return la + lb;
      4'd4:    return la - lb;
      4'd5:    return la * lb;
      4'd6:    return (lb == 0) ? 64'sd0 : la / lb;
      4'd7:    return (lb == 0) ? 64'sd0 : la % lb;
      default: return 64'sd0;
    endcase
  endfunction

  function automatic logic model_bad(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b, input logic [63:0] res);
`ifdef INSTR_READOUT_CHECK_EN
    return (opc <= 4'd7) && (model_expected(opc, a, b) != longint'(res));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 40)) - 32'd20;
    return $urandom;
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < DEPTH; i++) begin
      int sel;
      sel = $urandom_range(0, 11);
      m_opc[i] = (sel <= 8) ? 4'(sel) : 4'($urandom_range(9, 15));
      m_a[i]   = pick_operand();
      m_b[i]   = ($urandom_range(0, 4) == 0) ? 32'd0 : pick_operand();
      if (m_opc[i] <= 4'd7) m_res[i] = model_expected(m_opc[i], m_a[i], m_b[i]);
      else                  m_res[i] = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) m_res[i] = m_res[i] ^ (64'd1 << $urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) m_b[i] = m_b[i] ^ 32'h10;  // load error
    end
  endtask

  task automatic set_entry(input int i, input logic [3:0] opc, input int a, input int b, input longint res);
    m_opc[i] = opc; m_a[i] = a; m_b[i] = b; m_res[i] = res;
  endtask

  task automatic push_expected(input int sa, input int cnt);
    int mc;
    mc = 0;
    for (int i = 0; i < cnt; i++) begin
      exp_t e;
      e.addr = ADDR_W'((sa + i) % DEPTH);
      e.opc  = m_opc[e.addr];
      e.a    = m_a[e.addr];
      e.b    = m_b[e.addr];
      e.res  = m_res[e.addr];
      e.bad  = model_bad(e.opc, e.a, e.b, e.res);
      if (e.bad && mc < (2 ** (ADDR_W + 1)) - 1) mc++;
      e.cnt  = (ADDR_W+1)'(mc);
      sb.push_back(e);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = low for 5 cycles per entry.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (!out_valid)      begin out_ready = 1'b0; lowcnt = 0; end
        else if (lowcnt < 5) begin out_ready = 1'b0; lowcnt++;   end
        else                 begin out_ready = 1'b1; lowcnt = 0; end
      end
    endcase
  end

  // Monitor: compares every presented entry against the queue head.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        valid_seen++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_entry: got addr %0d expected none", out_addr);
        end else begin
          mon_e = sb[0];
          chk("entry", {out_addr, out_opc, out_op_a, out_op_b, out_result},
                       {mon_e.addr, mon_e.opc, mon_e.a, mon_e.b, mon_e.res});
          chk("out_mismatch", out_mismatch, mon_e.bad);
          chk("mismatch_cnt", mismatch_cnt, mon_e.cnt);
          if (out_ready) begin
            void'(sb.pop_front());
            hs_count++;
          end
        end
      end
      if (done) begin
        done_seen++;
        chk("done_queue_empty", sb.size(), 0);
      end
    end
  end

  task automatic do_start(input int sa, input int cnt);
    start = 1'b1; start_addr = ADDR_W'(sa); count = (ADDR_W+1)'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (done_seen < done_exp && n < 3000) begin @(posedge clk); n++; end
    chk({name, "_done"}, done_seen, done_exp);
    chk({name, "_drained"}, sb.size(), 0);
    sb.delete();
    done_seen = done_exp;
    @(posedge clk); #1;
  endtask

  task automatic run_sweep(input string name, input int sa, input int cnt, input int mode, input bit interfere);
    rmode = mode;
    @(posedge clk); #1;
    push_expected(sa, cnt);
    done_exp++;
    do_start(sa, cnt);
    if (interfere) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      if (busy) do_start(0, 1);
    end
    wait_sweep(name);
  endtask

  initial begin
    #400_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] vbits, dbits;
    int base, n, v0, d0;
    randomize_mem();
    #2;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset_read_pointer", read_pointer, 0);
    chk("reset_out_fields", {out_addr, out_result, mismatch_cnt}, 0);
    @(negedge clk); reset_n = 1'b1;

    // Basic sweep with exact handshake timing.
    set_entry(4, 4'd3, 3, 5, 8);
    set_entry(5, 4'd4, 10, 4, 6);
    set_entry(6, 4'd5, -2, 7, -14);
    rmode = 0;
    @(posedge clk); #1;
    push_expected(4, 3);
    done_exp++;
    do_start(4, 3);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vbits[k] = out_valid;
      dbits[k] = done;
    end
    chk("basic_valid_timing", vbits, 7'b0101010);
    chk("basic_done_timing", dbits, 7'b1000000);
    wait_sweep("basic");

    // Zero count: done one cycle after start, no entries.
    v0 = valid_seen;
    @(posedge clk); #1;
    done_exp++;
    do_start(9, 0);
    @(negedge clk);
    chk("count0_done", {done, out_valid}, 2'b10);
    wait_sweep("count0");
    chk("count0_no_entries", valid_seen - v0, 0);

    run_sweep("wrap_backpressure", 30, 4, 2, 1'b0);
    run_sweep("full_depth", 5, 32, 0, 1'b0);

    set_entry(10, 4'd6, 9, 0, 0);
    set_entry(11, 4'd3, 1, 2, 4);
    set_entry(12, 4'd3, 1, 7, 3);
    set_entry(13, 4'd8, 2, 3, 99);
    run_sweep("check_entries", 10, 4, 1, 1'b0);

    randomize_mem();
    run_sweep("start_while_busy", 8, 6, 0, 1'b1);

    // Reset in the middle of a sweep.
    randomize_mem();
    rmode = 0;
    @(posedge clk); #1;
    base = hs_count;
    push_expected(0, 8);
    do_start(0, 8);
    n = 0;
    while (hs_count < base + 3 && n < 100) begin @(posedge clk); n++; end
    chk("reset_mid_handshakes", hs_count - base, 3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_async", {out_valid, busy, read_pointer}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    v0 = valid_seen; d0 = done_seen;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_mid_quiet", {valid_seen - v0, done_seen - d0}, 0);
    chk("reset_mid_idle", busy, 1'b0);

    // Randomized sweeps.
    for (int s = 0; s < 30; s++) begin
      int sa, cnt;
      randomize_mem();
      sa  = $urandom_range(0, DEPTH - 1);
      cnt = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : DEPTH) : $urandom_range(1, DEPTH);
      run_sweep("random", sa, cnt, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
